// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the pop-to-stream prefetch block.
// Definitions only: no logic, no latency, no flow control.
package fifo_pkg;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;

    // One slot per in-flight pop plus headroom for a full-rate stream.
    function automatic int buf_depth(input int read_latency);
        return read_latency + 2;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/prefetch_ring_buf.sv
// Circular output buffer; a write shows up at the head one cycle later.
// Never stalls its writer: a write into a full buffer is a protocol error and is asserted on.
module prefetch_ring_buf
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = 64,
    parameter int  DEPTH      = 3,
    localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W      = count_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_dat_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_dat_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  empty_o
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_wr, do_rd, full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_wr    = wr_en_i & ~clr_i;
        do_rd    = rd_en_i & (count_q != '0) & ~clr_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_wr, do_rd})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is deliberately left unreset; head data is meaningless while empty.
    always_ff @(posedge clk_i) begin
        if (do_wr && !rst_i) mem_q[wr_ptr_q] <= wr_dat_i;
    end

    assign full     = (count_q == CNT_FULL);
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign count_o  = count_q;
    assign empty_o  = (count_q == '0);

    overflow_a: assert property (@(posedge clk_i) disable iff (rst_i || clr_i)
        !(wr_en_i && full))
        else $error("prefetch_ring_buf: write into full buffer");

endmodule

// File: rtl/fifo_pop_prefetch.sv
// Turns a fixed-latency FIFO pop port into a valid/ready stream; pop to valid_o is READ_LATENCY+1 cycles.
// Pops only while buffered plus in-flight words leave room, so ready_i low never loses data.
module fifo_pop_prefetch
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH   = 64,
    parameter int  READ_LATENCY = 1,
    localparam int BUF_DEPTH    = buf_depth(READ_LATENCY),
    localparam int CNT_W        = count_width(BUF_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_pop_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CNT_W-1:0]      count_o
);

    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);

    logic [READ_LATENCY-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]        inflight;
    logic [CNT_W:0]          demand;
    logic                    pop, arrive, rd_en, buf_empty;

    // Credit check uses only registered state, keeping ready_i off the pop path.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CNT_W'(tag_q[i]);
        end
        demand = {1'b0, count_o} + {1'b0, inflight};
        pop    = ~rst_i & ~flush_i & ~fifo_empty_i & (demand < DEPTH_C);
    end

    always_comb begin
        tag_d = '0;
        if (!flush_i) begin
            tag_d[0] = pop;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_d[i] = tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) tag_q <= '0;
        else       tag_q <= tag_d;
    end

    assign arrive = tag_q[READ_LATENCY-1];
    assign rd_en  = valid_o & ready_i;

    prefetch_ring_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_ring (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (flush_i),
        .wr_en_i  (arrive),
        .wr_dat_i (fifo_data_i),
        .rd_en_i  (rd_en),
        .rd_dat_o (data_o),
        .count_o  (count_o),
        .empty_o  (buf_empty)
    );

    assign valid_o    = ~buf_empty;
    assign fifo_pop_o = pop;

    lat_legal_a: assert property (@(posedge clk_i)
        (READ_LATENCY >= READ_LATENCY_MIN) && (READ_LATENCY <= READ_LATENCY_MAX))
        else $error("fifo_pop_prefetch: READ_LATENCY out of range");

endmodule

// File: doc/fifo_pop_prefetch.md
FIFO_POP_PREFETCH -- requirements
Module: fifo_pop_prefetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: width of every data word.
REQ-002 SHALL have parameter READ_LATENCY, default 1, legal values 1..2: cycles from pop_o high to the FIFO read data being valid.
REQ-003 SHALL have localparam BUF_DEPTH = READ_LATENCY+2: number of entries in the output buffer.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 flush_i  in  1  discard all buffered and in-flight words.
REQ-007 fifo_empty_i  in  1  upstream fifo_v3 empty flag.
REQ-008 fifo_data_i  in  DATA_WIDTH  upstream fifo_v3 read data.
REQ-009 fifo_pop_o  out  1  pop request to upstream fifo_v3.
REQ-010 valid_o  out  1  data_o holds a word.
REQ-011 ready_i  in  1  the consumer accepts data_o this cycle.
REQ-012 data_o  out  DATA_WIDTH  head word of the output buffer.
REQ-013 count_o  out  $clog2(BUF_DEPTH+1)  number of words in the output buffer.

Function
REQ-014 SHALL convert the FIFO pop interface, which has a fixed read latency, into a valid/ready stream without loss, duplication or reordering.
REQ-015 fifo_pop_o SHALL be 1 when all of these hold: fifo_empty_i=0; flush_i=0; rst_i=0; and occupancy + in-flight < BUF_DEPTH.
REQ-016 fifo_pop_o SHALL have no combinational path from ready_i or valid_o.
REQ-017 In-flight tracking SHALL use a READ_LATENCY-deep shift register of pop tags.
- A tag leaving the shift register writes fifo_data_i into the buffer tail in that cycle.
REQ-018 The output buffer SHALL be a circular buffer of BUF_DEPTH entries.
- Read and write pointers wrap from BUF_DEPTH-1 to 0.
- Occupancy counts 0..BUF_DEPTH.
REQ-019 valid_o SHALL equal (occupancy != 0).
- data_o SHALL be the head entry, driven from a register or buffer storage; data_o is not muxed from fifo_data_i.
- Latency from fifo_pop_o to valid_o is therefore READ_LATENCY+1 cycles.
REQ-020 A transfer SHALL occur when valid_o and ready_i are both 1; the read pointer then advances.
REQ-021 When an arrival and a transfer happen in the same cycle, occupancy SHALL be unchanged and both pointers SHALL advance.
REQ-022 With fifo_empty_i held at 0 and ready_i held at 1, the block SHALL sustain one transfer per cycle.
REQ-023 While valid_o=1 and ready_i=0, data_o and valid_o SHALL hold stable.
REQ-024 The buffer SHALL never overflow; an arrival into a full buffer is impossible by construction.
- An assertion SHALL flag any arrival into a full buffer.
REQ-025 flush_i=1 SHALL have the following effect in the next cycle:
- occupancy, pointers and in-flight tags are cleared;
- words returned for pops issued before the flush are discarded;
- valid_o=0.
REQ-026 A transfer coinciding with flush_i is still considered taken by the consumer.
REQ-027 flush_i does not drive the upstream FIFO's flush; the integrating level connects both.

Reset
REQ-028 On rst_i=1 at a clock edge, the following SHALL clear to 0: occupancy, pointers, in-flight tags, valid_o and count_o.
REQ-029 fifo_pop_o SHALL be 0 combinationally while rst_i=1.
REQ-030 Buffer data storage SHALL not be reset; data_o is don't-care while valid_o=0.
REQ-031 Reset asserted mid-stream SHALL behave identically to flush_i, with priority over flush_i and all other activity.

Structure
REQ-032 A shared package fifo_pkg SHALL hold the following; the module imports them:
- the legal READ_LATENCY range;
- the BUF_DEPTH derivation function;
- the count width function.
REQ-033 A single sub-module, prefetch_ring_buf, SHALL implement the circular buffer, with write/read enables, occupancy and head data.
- The pop and credit logic lives in fifo_pop_prefetch.

Verification
REQ-034 Scenario: reset, then 8 words 0x1..0x8 preloaded in the model FIFO, ready_i=1, READ_LATENCY=1.
- Required response: first valid_o 2 cycles after the first fifo_pop_o.
- 8 back-to-back transfers in order, then valid_o=0.
REQ-035 Scenario: continuous stream with ready_i=0 for 10 cycles.
- Required response: count_o saturates at 3 and fifo_pop_o stops.
- No overflow assertion fires.
- On release, words continue in order with none lost.
REQ-036 Scenario: flush_i pulsed while count_o=2 and 1 pop is in flight.
- Required response: valid_o=0 the next cycle.
- The in-flight word never appears on data_o.
- Subsequent words start from the first word popped after the flush.
REQ-037 Scenario: random ready_i (50%) and random fifo_empty_i with 1000 words, for READ_LATENCY=1 and READ_LATENCY=2.
- Required response: the scoreboard matches exactly.
- Throughput is 1 word/cycle during windows where both inputs are held favourable.
REQ-038 Scenario: rst_i asserted for 1 cycle mid-stream with count_o=3.
- Required response: next cycle valid_o=0, count_o=0 and fifo_pop_o=0 during reset.
- Normal operation resumes the cycle after rst_i is deasserted.
